// File: rtl/send_sched.sv
// Send scheduler: streams data_length register-file words to one destination PE.
// Each beat is handed to the destination PE once that PE is ready.
module send_sched (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_inst_valid,
    output logic       io_inst_ready,
    input  logic [7:0] io_inst_bits,
    output logic [2:0] io_rf_addr,
    input  logic [7:0] io_rf_data,
    output logic       io_out_valid,
    input  logic [3:0] io_out_ready,
    output logic [7:0] io_out_bits,
    output logic [1:0] io_out_dest,
    output logic       io_out_last,
    output logic       io_busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0] r_state;
    logic [1:0] r_dest;
    logic [2:0] r_ptr;
    logic [2:0] r_remaining;

    logic       w_send;
    logic       w_last;
    logic       w_fire;
    logic       w_accept;
    logic [1:0] w_inst_dest;
    logic [2:0] w_inst_addr;
    logic [2:0] w_inst_len;

    assign w_inst_dest = io_inst_bits[1:0];
    assign w_inst_addr = io_inst_bits[4:2];
    assign w_inst_len  = io_inst_bits[7:5];

    assign w_send = (r_state == ST_SEND);
    assign w_last = (r_remaining == 3'd1);
    // Only the addressed PE's ready bit matters.
    assign w_fire = w_send & io_out_ready[r_dest];

    // Accepting on the final beat gives zero-bubble back-to-back instructions.
    assign io_inst_ready = ~w_send | (w_fire & w_last);
    assign w_accept      = io_inst_valid & io_inst_ready;

    assign io_out_valid = w_send;
    assign io_busy      = w_send;
    assign io_out_last  = w_send & w_last;
    assign io_rf_addr   = r_ptr;
    assign io_out_dest  = r_dest;
    assign io_out_bits  = io_rf_data;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_dest      <= 2'd0;
            r_ptr       <= 3'd0;
            r_remaining <= 3'd0;
        end else if (w_accept) begin
            if (w_inst_len == 3'd0) begin
                r_state <= ST_IDLE;
            end else begin
                r_state     <= ST_SEND;
                r_dest      <= w_inst_dest;
                r_ptr       <= w_inst_addr;
                r_remaining <= w_inst_len;
            end
        end else if (w_fire) begin
            if (w_last) begin
                r_state <= ST_IDLE;
            end else begin
                r_ptr       <= r_ptr + 3'd1;
                r_remaining <= r_remaining - 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_send_sched.sv
// Directed bench for send_sched: per-cycle vector table plus a reset-abort sequence.
module tb_send_sched;

    logic       clock;
    logic       reset;
    logic       io_inst_valid;
    logic       io_inst_ready;
    logic [7:0] io_inst_bits;
    logic [2:0] io_rf_addr;
    logic [7:0] io_rf_data;
    logic       io_out_valid;
    logic [3:0] io_out_ready;
    logic [7:0] io_out_bits;
    logic [1:0] io_out_dest;
    logic       io_out_last;
    logic       io_busy;

    int checks;
    int failures;

    send_sched dut (
        .clock         (clock),
        .reset         (reset),
        .io_inst_valid (io_inst_valid),
        .io_inst_ready (io_inst_ready),
        .io_inst_bits  (io_inst_bits),
        .io_rf_addr    (io_rf_addr),
        .io_rf_data    (io_rf_data),
        .io_out_valid  (io_out_valid),
        .io_out_ready  (io_out_ready),
        .io_out_bits   (io_out_bits),
        .io_out_dest   (io_out_dest),
        .io_out_last   (io_out_last),
        .io_busy       (io_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register-file model: distinct value per address.
    function automatic logic [7:0] rf_val(input logic [2:0] a);
        return 8'h30 + 8'h11 * {5'd0, a};
    endfunction

    assign io_rf_data = rf_val(io_rf_addr);

    typedef struct {
        logic       iv;
        logic [7:0] ib;
        logic [3:0] ordy;
        logic       e_ir;
        logic       e_ov;
        logic [2:0] e_addr;
        logic [1:0] e_dest;
        logic       e_last;
        logic       e_busy;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic exp_out(input string tag, input logic ir, input logic ov, input logic [2:0] addr,
                           input logic [1:0] dest, input logic last, input logic busy);
        chk({tag, ".inst_ready"}, {7'd0, io_inst_ready}, {7'd0, ir});
        chk({tag, ".out_valid"},  {7'd0, io_out_valid},  {7'd0, ov});
        chk({tag, ".rf_addr"},    {5'd0, io_rf_addr},    {5'd0, addr});
        chk({tag, ".out_dest"},   {6'd0, io_out_dest},   {6'd0, dest});
        chk({tag, ".out_last"},   {7'd0, io_out_last},   {7'd0, last});
        chk({tag, ".busy"},       {7'd0, io_busy},       {7'd0, busy});
        if (ov) chk({tag, ".out_bits"}, io_out_bits, rf_val(addr));
        $display("cyc %s iv=%0b ib=%02h ordy=%04b -> ir=%0b ov=%0b addr=%0d dest=%0d last=%0b busy=%0b bits=%02h",
                 tag, io_inst_valid, io_inst_bits, io_out_ready, io_inst_ready, io_out_valid,
                 io_rf_addr, io_out_dest, io_out_last, io_busy, io_out_bits);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //             iv    ib     ordy     ir    ov  addr dest last busy
        // len3 addr1 pe1, only PE1 ready
        vecs[0]  = '{1'b1, 8'h65, 4'b0010, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 4'b0010, 1'b0, 1'b1, 3'd1, 2'd1, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 8'h00, 4'b0010, 1'b0, 1'b1, 3'd2, 2'd1, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 8'h00, 4'b0010, 1'b1, 1'b1, 3'd3, 2'd1, 1'b1, 1'b1};
        // len2 addr7 pe0: address wraps 7 -> 0
        vecs[4]  = '{1'b1, 8'h5C, 4'b1111, 1'b1, 1'b0, 3'd3, 2'd1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 4'b1111, 1'b0, 1'b1, 3'd7, 2'd0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 8'h00, 4'b1111, 1'b1, 1'b1, 3'd0, 2'd0, 1'b1, 1'b1};
        // len0: consumed, nothing sent
        vecs[7]  = '{1'b1, 8'h0E, 4'b1111, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0};
        // len2 addr5 pe2, PE2 stalled five cycles
        vecs[8]  = '{1'b1, 8'h56, 4'b1011, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 4'b1011, 1'b0, 1'b1, 3'd5, 2'd2, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 8'h00, 4'b1011, 1'b0, 1'b1, 3'd5, 2'd2, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 8'h00, 4'b1011, 1'b0, 1'b1, 3'd5, 2'd2, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 8'h00, 4'b1011, 1'b0, 1'b1, 3'd5, 2'd2, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 8'h00, 4'b1011, 1'b0, 1'b1, 3'd5, 2'd2, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 8'h00, 4'b1111, 1'b0, 1'b1, 3'd5, 2'd2, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 8'h00, 4'b1111, 1'b1, 1'b1, 3'd6, 2'd2, 1'b1, 1'b1};
        // back-to-back: len1 addr2 pe3 then len2 addr4 pe0 on its last beat
        vecs[16] = '{1'b1, 8'h2B, 4'b1111, 1'b1, 1'b0, 3'd6, 2'd2, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 8'h50, 4'b1111, 1'b1, 1'b1, 3'd2, 2'd3, 1'b1, 1'b1};
        vecs[18] = '{1'b0, 8'h00, 4'b1111, 1'b0, 1'b1, 3'd4, 2'd0, 1'b0, 1'b1};
        vecs[19] = '{1'b0, 8'h00, 4'b1111, 1'b1, 1'b1, 3'd5, 2'd0, 1'b1, 1'b1};
        vecs[20] = '{1'b0, 8'h00, 4'b1111, 1'b1, 1'b0, 3'd5, 2'd0, 1'b0, 1'b0};

        reset         = 1'b0;
        io_inst_valid = 1'b0;
        io_inst_bits  = 8'h00;
        io_out_ready  = 4'b0000;
        repeat (3) @(negedge clock);
        exp_out("reset", 1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);

        // Release at a negedge; the first vector is accepted on the very next rising edge.
        reset = 1'b1;
        for (int i = 0; i < NV; i++) begin
            io_inst_valid = vecs[i].iv;
            io_inst_bits  = vecs[i].ib;
            io_out_ready  = vecs[i].ordy;
            #1;
            exp_out($sformatf("v%0d", i), vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_addr,
                    vecs[i].e_dest, vecs[i].e_last, vecs[i].e_busy);
            @(negedge clock);
        end

        // Asynchronous reset on the second beat of a len4 instruction (addr3, pe1).
        io_inst_valid = 1'b1; io_inst_bits = 8'h8D; io_out_ready = 4'b1111;
        #1 exp_out("ra0", 1'b1, 1'b0, 3'd5, 2'd0, 1'b0, 1'b0);
        @(negedge clock);
        io_inst_valid = 1'b0; io_inst_bits = 8'h00;
        #1 exp_out("ra1", 1'b0, 1'b1, 3'd3, 2'd1, 1'b0, 1'b1);
        @(negedge clock);
        #1 exp_out("ra2", 1'b0, 1'b1, 3'd4, 2'd1, 1'b0, 1'b1);
        reset = 1'b0;
        #1 exp_out("ra_rst", 1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
        @(negedge clock);
        #1 exp_out("ra_hold", 1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
        reset = 1'b1;
        // New instruction len1 addr6 pe2 must start from its own address.
        io_inst_valid = 1'b1; io_inst_bits = 8'h3A;
        #1 exp_out("rb0", 1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
        @(negedge clock);
        io_inst_valid = 1'b0; io_inst_bits = 8'h00;
        #1 exp_out("rb1", 1'b1, 1'b1, 3'd6, 2'd2, 1'b1, 1'b1);
        @(negedge clock);
        #1 exp_out("rb2", 1'b1, 1'b0, 3'd6, 2'd2, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
